sample_burst_ctrl: RTL
======================

Name: sample_burst_ctrl

Overview:
- Sits directly downstream of the UART command decoder. Consumes its one-cycle command strobes (reset / sample / decim) and 4-bit parameter.
- Captures a burst of decimated samples from the acquisition stream into an internal buffer.
- Drains the buffer byte-by-byte to the UART transmitter over a valid/ready handshake.

Parameters:
- DATA_SIZE, 8, width of samples, parameter bus and TX bytes.
- DEPTH_LOG2, 4, log2 of buffer depth. Depth 16 equals the maximum burst length.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_reset  in  1  one-cycle soft-reset strobe from the command decoder
- i_cmd_sample  in  1  one-cycle start-burst strobe
- i_cmd_decim  in  1  one-cycle set-decimation strobe
- i_param  in  DATA_SIZE  command parameter; only [3:0] used
- i_data  in  DATA_SIZE  acquisition sample
- i_data_valid  in  1  i_data qualifier, one sample per high cycle
- o_tx_data  out  DATA_SIZE  byte to UART TX
- i_tx_ready  in  1  UART TX accepts byte
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  state != IDLE
- o_decim  out  4  current decimation setting D
- o_cmd_drop  out  1  one-cycle pulse: sample command ignored

Behaviour:
- Reset (i_reset):
  - State IDLE; pointers, counters and D cleared.
  - All outputs 0: o_tx_data=0, o_tx_valid=0, o_busy=0, o_decim=0, o_cmd_drop=0.
- Decimation register:
  - i_cmd_decim in any state: D <= i_param[3:0] next cycle.
  - D=n keeps 1 of every n+1 valid samples; D=0 keeps all.
  - D is copied into an active copy at burst start. A change mid-burst applies to the next burst only.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - On i_cmd_sample: remaining <= i_param[3:0] (burst length N = P+1, 1..16).
  - Also: decim counter <= 0, wr_ptr = rd_ptr = 0, go to CAPTURE next cycle.
  - i_data_valid is ignored in IDLE and in the strobe cycle itself.
- CAPTURE, on each i_data_valid:
  - If decim counter == 0: write i_data at wr_ptr, wr_ptr++, decim counter <= active D.
    - If remaining == 0 (last sample), go to DRAIN; otherwise remaining--.
  - Else: decim counter--.
  - Cycles without i_data_valid change nothing.
- DRAIN:
  - o_tx_valid is asserted the cycle after the last capture write, with o_tx_data = buf[0].
  - A byte transfers on o_tx_valid & i_tx_ready; rd_ptr++ and the next byte is presented the following cycle.
  - Bytes go out back-to-back if i_tx_ready stays high. One byte per cycle maximum.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid hold stable.
  - o_tx_valid never drops without a transfer, except on reset.
  - After the N-th transfer: o_tx_valid=0 and the state returns to IDLE the next cycle.
- Bytes are sent in capture order, unmodified, DATA_SIZE bits each.
- Buffer boundaries:
  - N=16 fills the buffer exactly; wr_ptr wraps to 0, and a separate count (not pointer equality) marks completion.
  - There is no overflow path, because capture stops at N.
- i_cmd_sample while o_busy=1: ignored, the burst is unaffected, and o_cmd_drop pulses for 1 cycle.
- i_cmd_reset in any state (soft reset):
  - Next cycle: state IDLE, o_tx_valid=0, pointers and counters cleared, o_cmd_drop=0.
  - D is retained.
  - A partially drained burst is discarded.
- Simultaneous strobes in the same cycle:
  - i_cmd_reset takes priority over i_cmd_sample, which is then not started and not flagged as dropped.
  - i_cmd_decim together with i_cmd_sample in IDLE: the new burst uses the old D; the new D applies to the following burst.
- i_reset mid-burst: identical to the power-on reset, including clearing D.
- o_busy is registered and high from the cycle after the accepted sample strobe until the IDLE return.

Test Plan:
- Reset / idle: assert i_reset 2 cycles, then feed i_data_valid -> all outputs 0, o_busy=0, no TX.
- Basic burst: D=0; sample strobe with P=3; feed 0x10,0x11,0x12,0x13 on consecutive cycles with i_tx_ready=1 -> TX 0x10,0x11,0x12,0x13 on 4 consecutive cycles; o_busy falls after the last transfer.
- Decimation: decim strobe P=2, then sample strobe P=1; feed 0x00..0x05 -> TX exactly 0x00,0x03; o_decim=2.
- Backpressure and full buffer: D=0, P=15, feed 0x20..0x2F; hold i_tx_ready=0 for 5 cycles during DRAIN -> o_tx_data held at the current byte; all 16 bytes 0x20..0x2F delivered in order.
- Soft reset mid-capture: P=7, feed 3 samples, pulse i_cmd_reset -> o_busy=0 next cycle, no TX. A following P=0 burst with 0xAA -> TX 0xAA only.
- Drop and priority:
  - Sample strobe during DRAIN -> o_cmd_drop pulses once; the original burst completes intact.
  - Reset and sample strobes in the same cycle while in IDLE -> remains IDLE, o_cmd_drop=0.

Source files
------------

// File: rtl/sample_burst_ctrl.sv
// Burst capture controller: collects a decimated burst of samples into a small
// buffer on command, then drains it byte-by-byte to the UART transmitter.
module sample_burst_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_reset,
    input  logic                 i_cmd_sample,
    input  logic                 i_cmd_decim,
    input  logic [DATA_SIZE-1:0] i_param,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_data_valid,
    output logic [DATA_SIZE-1:0] o_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_tx_valid,
    output logic                 o_busy,
    output logic [3:0]           o_decim,
    output logic                 o_cmd_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              decim_q;
    logic [3:0]              active_d;
    logic [3:0]              decim_cnt;
    logic [3:0]              remaining;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0]   last_idx;
    logic                    cmd_drop_q;
    logic [DATA_SIZE-1:0]    mem [DEPTH];

    logic                    start;
    logic                    capture_keep;
    logic                    tx_fire;
    logic                    drain_done;
    logic                    unused_param;

    assign unused_param = &{1'b0, i_param[DATA_SIZE-1:4]};

    // Valid/ready: a byte moves on any edge where o_tx_valid and i_tx_ready are
    // both high; valid and data stay stable until that happens.
    always_comb begin
        start        = (state == IDLE) && i_cmd_sample && !i_cmd_reset;
        capture_keep = (state == CAPTURE) && i_data_valid && (decim_cnt == 4'd0);
        tx_fire      = (state == DRAIN) && i_tx_ready;
        drain_done   = tx_fire && (rd_ptr == last_idx);
    end

    always_comb begin
        state_next = state;
        if (i_cmd_reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = CAPTURE;
                CAPTURE: if (capture_keep && (remaining == 4'd0)) state_next = DRAIN;
                DRAIN:   if (drain_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            decim_q    <= 4'd0;
            active_d   <= 4'd0;
            decim_cnt  <= 4'd0;
            remaining  <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_idx   <= '0;
            cmd_drop_q <= 1'b0;
        end else begin
            state      <= state_next;
            cmd_drop_q <= i_cmd_sample && (state != IDLE) && !i_cmd_reset;
            if (i_cmd_decim) decim_q <= i_param[3:0];

            if (i_cmd_reset) begin
                decim_cnt <= 4'd0;
                remaining <= 4'd0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                last_idx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_cmd_sample) begin
                            // decim_q here is the pre-strobe value, so a decim
                            // strobe in the same cycle only affects later bursts.
                            remaining <= i_param[3:0];
                            last_idx  <= DEPTH_LOG2'(i_param[3:0]);
                            active_d  <= decim_q;
                            decim_cnt <= 4'd0;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (i_data_valid) begin
                            if (decim_cnt == 4'd0) begin
                                wr_ptr    <= wr_ptr + 1'b1;
                                decim_cnt <= active_d;
                                if (remaining != 4'd0) remaining <= remaining - 1'b1;
                            end else begin
                                decim_cnt <= decim_cnt - 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (tx_fire) rd_ptr <= rd_ptr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && !i_cmd_reset && capture_keep) mem[wr_ptr] <= i_data;
    end

    // Completion is tracked by last_idx rather than pointer equality because a
    // full 16-entry burst wraps wr_ptr back onto rd_ptr.
    assign o_tx_valid = (state == DRAIN);
    assign o_tx_data  = o_tx_valid ? mem[rd_ptr] : '0;
    assign o_busy     = (state != IDLE);
    assign o_decim    = decim_q;
    assign o_cmd_drop = cmd_drop_q;

endmodule
